// File: rtl/emulador_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 emulator: state encodings, default
// timing constants (50 MHz clock) and a counter-width helper.
package emulador_hcsr04_pkg;

    typedef enum logic [3:0] {
        Inicial      = 4'd0,
        ContaTrigger = 4'd1,
        EsperaBurst  = 4'd2,
        GeraEcho     = 4'd3,
        Recupera     = 4'd4
    } estado_t;

    localparam int unsigned CiclosPorCmPadrao      = 2941;
    localparam int unsigned LarguraMinTriggerPadrao = 500;
    localparam int unsigned AtrasoBurstPadrao      = 10000;
    localparam int unsigned DistanciaMaxPadrao     = 400;
    localparam int unsigned TimeoutEchoPadrao      = 1900000;
    localparam int unsigned IntervaloRepousoPadrao = 50000;

    // Width of a counter that must hold values 0..m-1 (at least one bit).
    function automatic int unsigned largura(input int unsigned m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/emulador_hcsr04_if.sv
// Trigger/echo link between the ranging initiator and the emulated sensor,
// plus the distance stimulus and debug taps.
interface emulador_hcsr04_if;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       ocupado;
    logic [3:0] db_estado;
    logic [8:0] db_distancia;

    modport master (
        output trigger, distancia,
        input  echo, ocupado, db_estado, db_distancia
    );

    modport slave (
        input  trigger, distancia,
        output echo, ocupado, db_estado, db_distancia
    );
endinterface

// File: rtl/contador_m.sv
// Generic modulo-M counter: synchronous clear (zera) has priority over
// counting; fim flags the terminal value M-1.
module contador_m
    import emulador_hcsr04_pkg::*;
#(
    parameter  int unsigned M = 16,
    localparam int unsigned N = largura(M)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [N-1:0] q,
    output logic         fim
);

    assign fim = (q == N'(M - 1));

    // Count modulo M, wrapping to zero after the terminal value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (zera) begin
            q <= '0;
        end else if (conta) begin
            q <= fim ? '0 : q + N'(1);
        end
    end

endmodule

// File: rtl/emulador_hcsr04.sv
// HC-SR04 responder: validates the trigger width, waits the burst delay and
// returns an echo whose width is distance x cycles-per-cm (or a timeout).
module emulador_hcsr04
    import emulador_hcsr04_pkg::*;
#(
    parameter int unsigned CICLOS_POR_CM       = CiclosPorCmPadrao,
    parameter int unsigned LARGURA_MIN_TRIGGER = LarguraMinTriggerPadrao,
    parameter int unsigned ATRASO_BURST        = AtrasoBurstPadrao,
    parameter int unsigned DISTANCIA_MAX       = DistanciaMaxPadrao,
    parameter int unsigned TIMEOUT_ECHO        = TimeoutEchoPadrao,
    parameter int unsigned INTERVALO_REPOUSO   = IntervaloRepousoPadrao
) (
    input logic               clock,
    input logic               reset,
    emulador_hcsr04_if.slave  bus
);

    localparam int unsigned NTrig    = largura(LARGURA_MIN_TRIGGER + 1);
    localparam int unsigned NBurst   = largura(ATRASO_BURST);
    localparam int unsigned NSub     = largura(CICLOS_POR_CM);
    localparam int unsigned NCm      = largura(DISTANCIA_MAX);
    localparam int unsigned NTimeout = largura(TIMEOUT_ECHO);
    // A zero rest interval still needs a legal modulus; it is bypassed below.
    localparam int unsigned MRep     = (INTERVALO_REPOUSO > 0) ? INTERVALO_REPOUSO : 1;
    localparam int unsigned NRep     = largura(MRep);

    logic                sinc1, trig_s;
    estado_t             estado;
    logic                echo_q, ocupado_q;
    logic [8:0]          dist_q;
    logic [NCm-1:0]      cm_q;

    logic [NTrig-1:0]    q_trig;
    logic [NBurst-1:0]   q_burst;
    logic [NSub-1:0]     q_sub;
    logic [NTimeout-1:0] q_timeout;
    logic [NRep-1:0]     q_rep;
    logic                trig_ok, fim_burst, fim_sub, fim_timeout, fim_rep;
    logic                modo_timeout, cm_last, echo_fim;
    logic                unused_q;

    assign unused_q = ^{q_trig, q_burst, q_sub, q_timeout, q_rep};

    // Two-flop synchronizer for the asynchronous trigger input.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1  <= 1'b0;
            trig_s <= 1'b0;
        end else begin
            sinc1  <= bus.trigger;
            trig_s <= sinc1;
        end
    end

    // Trigger width counter saturates at the minimum; saturation means accepted.
    contador_m #(.M(LARGURA_MIN_TRIGGER + 1)) u_trigger (
        .clock (clock),
        .reset (reset),
        .zera  (estado != ContaTrigger),
        .conta ((estado == ContaTrigger) && trig_s && !trig_ok),
        .q     (q_trig),
        .fim   (trig_ok)
    );

    contador_m #(.M(ATRASO_BURST)) u_burst (
        .clock (clock),
        .reset (reset),
        .zera  (estado != EsperaBurst),
        .conta (estado == EsperaBurst),
        .q     (q_burst),
        .fim   (fim_burst)
    );

    // Sub-cycle counter: one wrap per centimetre of echo.
    contador_m #(.M(CICLOS_POR_CM)) u_sub_cm (
        .clock (clock),
        .reset (reset),
        .zera  (estado != GeraEcho),
        .conta ((estado == GeraEcho) && !modo_timeout),
        .q     (q_sub),
        .fim   (fim_sub)
    );

    contador_m #(.M(TIMEOUT_ECHO)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (estado != GeraEcho),
        .conta ((estado == GeraEcho) && modo_timeout),
        .q     (q_timeout),
        .fim   (fim_timeout)
    );

    contador_m #(.M(MRep)) u_repouso (
        .clock (clock),
        .reset (reset),
        .zera  (estado != Recupera),
        .conta (estado == Recupera),
        .q     (q_rep),
        .fim   (fim_rep)
    );

    assign modo_timeout = (dist_q == '0) || (32'(dist_q) > DISTANCIA_MAX);
    assign cm_last      = ((32'(cm_q) + 32'd1) == 32'(dist_q));
    assign echo_fim     = modo_timeout ? fim_timeout : (fim_sub && cm_last);

    // Measurement FSM with registered echo, busy flag and latched distance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= Inicial;
            echo_q    <= 1'b0;
            ocupado_q <= 1'b0;
            dist_q    <= '0;
            cm_q      <= '0;
        end else begin
            case (estado)
                Inicial: begin
                    if (trig_s) begin
                        estado    <= ContaTrigger;
                        ocupado_q <= 1'b1;
                    end
                end
                ContaTrigger: begin
                    if (!trig_s) begin
                        if (trig_ok) begin
                            dist_q <= bus.distancia;
                            estado <= EsperaBurst;
                        end else begin
                            estado    <= Inicial;
                            ocupado_q <= 1'b0;
                        end
                    end
                end
                EsperaBurst: begin
                    if (fim_burst) begin
                        estado <= GeraEcho;
                        echo_q <= 1'b1;
                        cm_q   <= '0;
                    end
                end
                GeraEcho: begin
                    if (echo_fim) begin
                        estado <= Recupera;
                        echo_q <= 1'b0;
                    end else if (fim_sub) begin
                        cm_q <= cm_q + NCm'(1);
                    end
                end
                Recupera: begin
                    if ((INTERVALO_REPOUSO == 0) || fim_rep) begin
                        estado    <= Inicial;
                        ocupado_q <= 1'b0;
                    end
                end
                default: begin
                    estado    <= Inicial;
                    echo_q    <= 1'b0;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.echo         = echo_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.db_estado    = estado;
    assign bus.db_distancia = dist_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Scoreboard bench for emulador_hcsr04: stimulus pushes expected echo timing,
// a negedge monitor measures echo rise, width and rest interval.
module tb_emulador_hcsr04;
    import emulador_hcsr04_pkg::*;

    localparam int unsigned C = 4;
    localparam int unsigned L = 5;
    localparam int unsigned A = 10;
    localparam int unsigned DMAX = 400;
    localparam int unsigned T = 2000;
    localparam int unsigned R = 20;

    typedef struct {
        int unsigned rise;
        int unsigned width;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    int unsigned exp_db = 0;

    // Monitor state
    logic        echo_prev;
    bit          active, resting;
    int unsigned rise_cyc, fall_cyc;
    exp_t        cur;

    emulador_hcsr04_if bus ();

    emulador_hcsr04 #(
        .CICLOS_POR_CM       (C),
        .LARGURA_MIN_TRIGGER (L),
        .ATRASO_BURST        (A),
        .DISTANCIA_MAX       (DMAX),
        .TIMEOUT_ECHO        (T),
        .INTERVALO_REPOUSO   (R)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference echo width: distance x cycles-per-cm in range, else timeout.
    function automatic int unsigned echo_width(input int unsigned d);
        return (d >= 1 && d <= DMAX) ? d * C : T;
    endfunction

    // Called at the negedge where trigger was just dropped: the next posedge
    // is the first one to sample it low (edge k).
    task automatic expect_meas(input int unsigned d);
        exp_t e;
        e.rise  = cyc + 1 + 2 + A;
        e.width = echo_width(d);
        sb.push_back(e);
        exp_db = d;
    endtask

    // Drive a trigger pulse of n clock cycles. When the sensor is idle the
    // pulse is accepted iff the high time after entering the counting state
    // (n - 1 cycles) reaches the minimum width.
    task automatic pulse(input int unsigned d, input int unsigned n, input bit idle);
        bus.distancia = 9'(d);
        bus.trigger   = 1'b1;
        repeat (n) @(negedge clock);
        bus.trigger = 1'b0;
        if (idle && (n - 1 >= L)) expect_meas(d);
    endtask

    task automatic wait_echo(input logic level);
        int n = 0;
        while (bus.echo !== level && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("echo_level_reached", bus.echo, level);
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge clock);
        while (bus.ocupado !== 1'b0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("idle_ocupado", bus.ocupado, 0);
        check("idle_estado", bus.db_estado, 0);
        repeat (2) @(negedge clock);
    endtask

    // Monitor: pops an expectation at each echo rise and checks timing.
    initial begin
        echo_prev = 1'b0;
        active    = 1'b0;
        resting   = 1'b0;
        rise_cyc  = 0;
        fall_cyc  = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                echo_prev = 1'b0;
                active    = 1'b0;
                resting   = 1'b0;
            end else begin
                if (bus.echo && !echo_prev) begin
                    check("echo_expected", sb.size() != 0, 1);
                    rise_cyc = cyc;
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        check("echo_rise_cycle", cyc, cur.rise);
                        active = 1'b1;
                    end
                end
                if (!bus.echo && echo_prev && active) begin
                    check("echo_width", cyc - rise_cyc, cur.width);
                    active   = 1'b0;
                    resting  = 1'b1;
                    fall_cyc = cyc;
                end
                if (resting && !bus.ocupado) begin
                    check("rest_interval", cyc - fall_cyc, R);
                    resting = 1'b0;
                end
                echo_prev = bus.echo;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.trigger   = 1'b0;
        bus.distancia = '0;
        repeat (3) @(negedge clock);
        check("reset_echo", bus.echo, 0);
        check("reset_ocupado", bus.ocupado, 0);
        check("reset_estado", bus.db_estado, 0);
        check("reset_db_distancia", bus.db_distancia, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Nominal 5 cm measurement
        pulse(5, 8, 1'b1);
        wait_idle();
        check("db_distancia_s1", bus.db_distancia, exp_db);

        // Short trigger is rejected and leaves the latched distance alone
        pulse(9, 3, 1'b1);
        wait_idle();
        check("db_distancia_s2", bus.db_distancia, exp_db);

        // Zero and out-of-range distances produce the timeout width
        pulse(0, 8, 1'b1);
        wait_idle();
        check("db_distancia_s3a", bus.db_distancia, exp_db);
        pulse(401, 8, 1'b1);
        wait_idle();
        check("db_distancia_s3b", bus.db_distancia, exp_db);

        // Distance change and extra triggers while busy are ignored
        pulse(5, 8, 1'b1);
        wait_echo(1'b1);
        pulse(300, 8, 1'b0);
        wait_echo(1'b0);
        @(negedge clock);
        pulse(77, 8, 1'b0);
        wait_idle();
        check("db_distancia_s4", bus.db_distancia, exp_db);

        // Reset in the middle of a 400 cm echo
        pulse(400, 8, 1'b1);
        wait_echo(1'b1);
        repeat (800) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset_echo", bus.echo, 0);
        check("midreset_estado", bus.db_estado, 0);
        check("midreset_ocupado", bus.ocupado, 0);
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        exp_db = 0;
        check("midreset_db_distancia", bus.db_distancia, exp_db);
        @(negedge clock);
        pulse(1, 8, 1'b1);
        wait_idle();

        // Trigger held across the end of the rest interval starts a new measurement
        pulse(20, 8, 1'b1);
        wait_echo(1'b1);
        wait_echo(1'b0);
        @(negedge clock);
        bus.distancia = 9'd37;
        bus.trigger   = 1'b1;
        repeat (30) @(negedge clock);
        bus.trigger = 1'b0;
        expect_meas(37);
        wait_idle();
        check("db_distancia_s6", bus.db_distancia, exp_db);

        // Randomized measurements, some rejected, some with distance changed mid-echo
        for (int i = 0; i < 10; i++) begin
            int unsigned d;
            int unsigned n;
            d = $urandom_range(0, 450);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(7, 12);
            pulse(d, n, 1'b1);
            if ((n - 1 >= L) && ($urandom_range(0, 1) == 1)) begin
                wait_echo(1'b1);
                bus.distancia = 9'($urandom_range(0, 511));
            end
            wait_idle();
            check("db_distancia_rand", bus.db_distancia, exp_db);
        end

        repeat (5) @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/emulador_hcsr04.md
Name: emulador_hcsr04

Overview:
Synthesizable model of the HC-SR04 ultrasonic sensor, i.e. the responder side of the trigger/echo protocol driven by interface_hcsr04.
- Accepts a trigger pulse.
- Waits a burst delay.
- Returns an echo pulse whose width encodes a distance supplied on an input port.
- Used for FPGA-in-the-loop and bench testing of the FRISCV cup-detection datapath without a physical sensor.

Parameters:
- CICLOS_POR_CM, 2941: clock cycles of echo per cm (58.82 us at 50 MHz).
- LARGURA_MIN_TRIGGER, 500: minimum synchronized trigger high time accepted (10 us).
- ATRASO_BURST, 10000: cycles from accepted trigger fall to echo rise (8 × 40 kHz burst, 200 us).
- DISTANCIA_MAX, 400: largest valid distance in cm.
- TIMEOUT_ECHO, 1900000: echo width for out-of-range or zero distance (38 ms).
- INTERVALO_REPOUSO, 50000: dead time after echo falls, during which triggers are ignored.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  trigger from the initiator; asynchronous to clock, passed through a 2-FF synchronizer internally.
- distancia  in  9  simulated distance, binary cm; sampled once per measurement.
- echo  out  1  echo pulse to the initiator; registered output.
- ocupado  out  1  high in every state except INICIAL.
- db_estado  out  4  current FSM state encoding.
- db_distancia  out  9  latched distance of the current or last measurement.

Behaviour:
- Reset:
  - Clock and reset as above; reset is asynchronous and active-high.
  - Reset forces: state INICIAL, echo=0, ocupado=0, db_distancia=0, db_estado=0, synchronizer flops=0, all counters=0.
  - Reset mid-operation drops echo in the same instant; no partial pulse resumes afterwards.
- Synchronizer: trig_s equals trigger delayed 2 edges. All FSM decisions use trig_s.
- INICIAL (0):
  - If trig_s=1, go to CONTA_TRIGGER.
  - The high-cycle counter is cleared on entry to CONTA_TRIGGER.
- CONTA_TRIGGER (1):
  - While trig_s=1, the counter increments and saturates at LARGURA_MIN_TRIGGER.
  - On trig_s=0 with count ≥ LARGURA_MIN_TRIGGER: latch distancia into db_distancia and go to ESPERA_BURST.
  - On trig_s=0 with count < LARGURA_MIN_TRIGGER: go back to INICIAL. No echo, nothing latched.
  - A trigger held high indefinitely keeps the FSM here.
- ESPERA_BURST (2): count ATRASO_BURST cycles, then go to GERA_ECHO.
- Echo rise timing:
  - Let k be the first clock edge that samples trigger=0.
  - echo first reads 1 after edge k+2+ATRASO_BURST.
  - This latency is exact, with no tolerance.
- GERA_ECHO (3):
  - echo=1 for exactly W cycles, then go to RECUPERA with echo=0.
  - W = db_distancia × CICLOS_POR_CM when 1 ≤ db_distancia ≤ DISTANCIA_MAX; otherwise W = TIMEOUT_ECHO.
  - W is generated with nested counters: a cycle counter modulo CICLOS_POR_CM plus a cm counter. No multiplier.
  - Changes on distancia after the latch do not affect W.
- RECUPERA (4): count INTERVALO_REPOUSO cycles, then go to INICIAL.
  - If INTERVALO_REPOUSO=0, go directly to INICIAL on the next edge.
- Trigger activity in ESPERA_BURST, GERA_ECHO or RECUPERA is ignored: no queuing and no restart.
  - A trigger already high when INICIAL is re-entered is treated as a new pulse. Its width counts from the INICIAL→CONTA_TRIGGER edge.
- Counter widths come from $clog2 of the largest parameter they count to. No overflow is possible for legal parameters.
- Unused state encodings go to INICIAL.

Decomposition:
- Shared header/package emulador_hcsr04_pkg holds:
  - the state encodings (INICIAL=0, CONTA_TRIGGER=1, ESPERA_BURST=2, GERA_ECHO=3, RECUPERA=4);
  - the default timing constants, so testbenches and the interface_hcsr04 bench share them.
- One sub-module is natural: contador_m, a generic modulo-M counter.
  - Inputs: zera, conta. Outputs: Q, fim.
  - Instantiated for the trigger width, the burst delay, the cm sub-cycle and the rest interval.
  - The FSM lives in the top-level module.

Test Plan:
All scenarios use CICLOS_POR_CM=4, LARGURA_MIN_TRIGGER=5, ATRASO_BURST=10, DISTANCIA_MAX=400, TIMEOUT_ECHO=2000, INTERVALO_REPOUSO=20.
1. distancia=5, trigger high 8 cycles → echo rises after edge k+12, stays high exactly 20 cycles; db_distancia=5; ocupado returns to 0 after 20 more cycles.
2. Trigger high 3 cycles → no echo; state goes back to INICIAL; db_distancia keeps its previous value.
3. distancia=0, then distancia=401, each with an 8-cycle trigger → echo width 2000 cycles in both cases.
4. distancia=5 latched, distancia changed to 300 during GERA_ECHO, a second trigger pulsed during GERA_ECHO and RECUPERA → single echo of 20 cycles; second trigger ignored.
5. reset asserted halfway through a 400 cm echo → echo=0 and db_estado=0 immediately. A subsequent valid trigger with distancia=1 → echo of 4 cycles.
6. Back-to-back: trigger held high across the end of RECUPERA → the new measurement starts and echo width is correct for the current distancia.
